// File: rtl/swd_pkg.sv
// Shared types and constants for the SWD host engine.
// Commands, ACK codes, FSM states and header/sequence helpers.
package swd_pkg;

    typedef enum logic [1:0] {
        CMD_XFER = 2'd0,
        CMD_LRST = 2'd1,
        CMD_JTAG = 2'd2,
        CMD_RSVD = 2'd3
    } cmd_e;

    localparam logic [2:0] ACK_OK    = 3'b001;
    localparam logic [2:0] ACK_WAIT  = 3'b010;
    localparam logic [2:0] ACK_FAULT = 3'b100;

    typedef enum logic [3:0] {
        IDLE,
        SEQ,
        HDR,
        TRN1,
        ACK,
        RDATA,
        TRN2,
        WDATA,
        TAIL,
        DONE
    } state_e;

    localparam int          LINE_RESET_LEN = 56;
    localparam logic [15:0] JTAG2SWD       = 16'hE79E;

    // Header byte, bit 0 goes out first.
    function automatic logic [7:0] swd_hdr(
        input logic       ap,
        input logic       rnw,
        input logic [1:0] a
    );
        return {1'b1, 1'b0, ap ^ rnw ^ a[0] ^ a[1],
                a[1], a[0], rnw, ap, 1'b1};
    endfunction

    // Bit idx of a sequence segment: a run of ones, then the
    // JTAG-to-SWD pattern (pat) or zeros.
    function automatic logic seq_bit(
        input logic       pat,
        input logic [6:0] idx
    );
        logic [6:0] k;
        k = idx - 7'(LINE_RESET_LEN);
        if (idx < 7'(LINE_RESET_LEN)) return 1'b1;
        if (pat) return JTAG2SWD[k[3:0]];
        return 1'b0;
    endfunction

    // Last bit index of the current sequence segment.
    function automatic logic [6:0] seq_last(
        input logic jtag,
        input logic tail
    );
        if (jtag && !tail) return 7'(LINE_RESET_LEN + 15);
        if (jtag) return 7'(LINE_RESET_LEN + 7);
        return 7'(LINE_RESET_LEN + 1);
    endfunction

endpackage

// File: rtl/swd_clkgen.sv
// SWCLK divider: toggles swclk every DIV_HALF clkin cycles while
// enabled, and flags the cycles where swclk rises or falls.
module swd_clkgen #(
    parameter int DIV_HALF = 24
) (
    input  logic clkin,
    input  logic rst,
    input  logic en,
    output logic swclk,
    output logic rise,
    output logic fall
);

    localparam logic [7:0] LAST = 8'(DIV_HALF - 1);

    logic [7:0] cnt;
    logic       tick;

    assign tick = en && (cnt == LAST);
    assign rise = tick && !swclk;
    assign fall = tick && swclk;

    // Half-period counter; held at zero with swclk low when idle.
    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            swclk <= 1'b0;
        end else if (!en) begin
            cnt   <= '0;
            swclk <= 1'b0;
        end else if (tick) begin
            cnt   <= '0;
            swclk <= ~swclk;
        end else begin
            cnt <= cnt + 8'd1;
        end
    end

endmodule

// File: rtl/swd_host.sv
// SWD host engine: runs one transfer, line reset or JTAG-to-SWD
// switch per accepted request and reports ACK/data/parity.
module swd_host
    import swd_pkg::*;
#(
    parameter int DIV_HALF    = 24,
    parameter int IDLE_CYCLES = 8
) (
    input  logic        clkin,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_cmd,
    input  logic        req_ap,
    input  logic        req_rnw,
    input  logic [1:0]  req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [2:0]  rsp_ack,
    output logic [31:0] rsp_rdata,
    output logic        rsp_perr,
    output logic        swclk,
    output logic        swdio_o,
    output logic        swdio_oe,
    input  logic        swdio_i
);

    localparam logic [6:0] TAIL_LAST = 7'(IDLE_CYCLES - 1);

    state_e      state;
    logic [6:0]  bcnt;
    logic [32:0] sr;
    logic [7:0]  hdr_q;
    logic        rnw_q;
    logic        jtag_q;
    logic        tail_q;
    logic [2:0]  ack_q;
    logic        clk_en;
    logic        rise;
    logic        fall;

    assign clk_en = (state != IDLE) && (state != DONE);

    swd_clkgen #(
        .DIV_HALF(DIV_HALF)
    ) u_clkgen (
        .clkin(clkin),
        .rst  (rst),
        .en   (clk_en),
        .swclk(swclk),
        .rise (rise),
        .fall (fall)
    );

    // Protocol FSM: drives on swclk fall, samples on swclk rise.
    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_ack   <= '0;
            rsp_rdata <= '0;
            rsp_perr  <= 1'b0;
            swdio_o   <= 1'b1;
            swdio_oe  <= 1'b0;
            bcnt      <= '0;
            sr        <= '0;
            hdr_q     <= '0;
            rnw_q     <= 1'b0;
            jtag_q    <= 1'b0;
            tail_q    <= 1'b0;
            ack_q     <= '0;
        end else begin
            rsp_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        bcnt      <= '0;
                        ack_q     <= '0;
                        rsp_perr  <= 1'b0;
                        tail_q    <= 1'b0;
                        hdr_q     <= swd_hdr(req_ap, req_rnw, req_addr);
                        rnw_q     <= req_rnw;
                        sr        <= {^req_wdata, req_wdata};
                        jtag_q    <= (req_cmd == CMD_JTAG);
                        // Header start bit and sequences both open with 1.
                        swdio_o   <= 1'b1;
                        swdio_oe  <= 1'b1;
                        state     <= (req_cmd == CMD_XFER) ? HDR : SEQ;
                    end
                end
                SEQ: begin
                    if (fall) begin
                        if (bcnt == seq_last(jtag_q, tail_q)) begin
                            bcnt    <= '0;
                            swdio_o <= 1'b1;
                            if (jtag_q && !tail_q) begin
                                tail_q <= 1'b1;
                            end else begin
                                swdio_oe <= 1'b0;
                                state    <= DONE;
                            end
                        end else begin
                            bcnt    <= bcnt + 7'd1;
                            swdio_o <= seq_bit(jtag_q && !tail_q,
                                               bcnt + 7'd1);
                        end
                    end
                end
                HDR: begin
                    if (fall) begin
                        if (bcnt == 7'd7) begin
                            bcnt     <= '0;
                            swdio_oe <= 1'b0;
                            state    <= TRN1;
                        end else begin
                            bcnt    <= bcnt + 7'd1;
                            swdio_o <= hdr_q[bcnt[2:0] + 3'd1];
                        end
                    end
                end
                TRN1: begin
                    if (fall) state <= ACK;
                end
                ACK: begin
                    if (rise) ack_q <= {swdio_i, ack_q[2:1]};
                    if (fall) begin
                        if (bcnt == 7'd2) begin
                            bcnt  <= '0;
                            state <= (ack_q == ACK_OK && rnw_q) ? RDATA
                                                                : TRN2;
                        end else begin
                            bcnt <= bcnt + 7'd1;
                        end
                    end
                end
                RDATA: begin
                    if (rise) sr <= {swdio_i, sr[32:1]};
                    if (fall) begin
                        if (bcnt == 7'd32) begin
                            bcnt      <= '0;
                            rsp_rdata <= sr[31:0];
                            rsp_perr  <= ^sr;
                            state     <= TRN2;
                        end else begin
                            bcnt <= bcnt + 7'd1;
                        end
                    end
                end
                TRN2: begin
                    if (fall) begin
                        bcnt     <= '0;
                        swdio_oe <= 1'b1;
                        if (ack_q == ACK_OK && !rnw_q) begin
                            swdio_o <= sr[0];
                            state   <= WDATA;
                        end else if (IDLE_CYCLES == 0) begin
                            swdio_o  <= 1'b1;
                            swdio_oe <= 1'b0;
                            state    <= DONE;
                        end else begin
                            swdio_o <= 1'b0;
                            state   <= TAIL;
                        end
                    end
                end
                WDATA: begin
                    if (fall) begin
                        if (bcnt == 7'd32) begin
                            bcnt <= '0;
                            if (IDLE_CYCLES == 0) begin
                                swdio_o  <= 1'b1;
                                swdio_oe <= 1'b0;
                                state    <= DONE;
                            end else begin
                                swdio_o <= 1'b0;
                                state   <= TAIL;
                            end
                        end else begin
                            bcnt    <= bcnt + 7'd1;
                            swdio_o <= sr[1];
                            sr      <= {1'b0, sr[32:1]};
                        end
                    end
                end
                TAIL: begin
                    if (fall) begin
                        if (bcnt == TAIL_LAST) begin
                            bcnt     <= '0;
                            swdio_o  <= 1'b1;
                            swdio_oe <= 1'b0;
                            state    <= DONE;
                        end else begin
                            bcnt <= bcnt + 7'd1;
                        end
                    end
                end
                DONE: begin
                    rsp_valid <= 1'b1;
                    rsp_ack   <= ack_q;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_swd_host.sv
// Scoreboard bench for swd_host: a pin recorder and target model
// feed a monitor that checks each response against queued values.
module tb_swd_host;

    localparam int DIV0   = 24;
    localparam int IDLE_N = 8;

    typedef struct {
        logic [2:0]   ack;
        logic [31:0]  rd;
        logic         perr;
        int           nclk;
        logic [255:0] oe;
        logic [255:0] o;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        rv    = 1'b0;
    logic [1:0]  cmd   = '0;
    logic        ap    = 1'b0;
    logic        rnw   = 1'b0;
    logic [1:0]  addr  = '0;
    logic [31:0] wdata = '0;
    logic        sel   = 1'b0;
    logic        tgt_i = 1'b1;

    logic        rdy0, rdy1, vld0, vld1, perr0, perr1;
    logic [2:0]  ack0, ack1;
    logic [31:0] rd0, rd1;
    logic        sck0, sck1, o0, o1, oe0, oe1;

    swd_host #(.DIV_HALF(DIV0), .IDLE_CYCLES(IDLE_N)) u_dut0 (
        .clkin(clk), .rst(rst), .req_valid(rv & ~sel), .req_ready(rdy0),
        .req_cmd(cmd), .req_ap(ap), .req_rnw(rnw), .req_addr(addr),
        .req_wdata(wdata), .rsp_valid(vld0), .rsp_ack(ack0),
        .rsp_rdata(rd0), .rsp_perr(perr0), .swclk(sck0),
        .swdio_o(o0), .swdio_oe(oe0), .swdio_i(tgt_i)
    );

    swd_host #(.DIV_HALF(1), .IDLE_CYCLES(IDLE_N)) u_dut1 (
        .clkin(clk), .rst(rst), .req_valid(rv & sel), .req_ready(rdy1),
        .req_cmd(cmd), .req_ap(ap), .req_rnw(rnw), .req_addr(addr),
        .req_wdata(wdata), .rsp_valid(vld1), .rsp_ack(ack1),
        .rsp_rdata(rd1), .rsp_perr(perr1), .swclk(sck1),
        .swdio_o(o1), .swdio_oe(oe1), .swdio_i(tgt_i)
    );

    logic        rdy_s, vld_s, perr_s, sck_s, o_s, oe_s;
    logic [2:0]  ack_s;
    logic [31:0] rd_s;
    assign rdy_s  = sel ? rdy1  : rdy0;
    assign vld_s  = sel ? vld1  : vld0;
    assign perr_s = sel ? perr1 : perr0;
    assign sck_s  = sel ? sck1  : sck0;
    assign o_s    = sel ? o1    : o0;
    assign oe_s   = sel ? oe1   : oe0;
    assign ack_s  = sel ? ack1  : ack0;
    assign rd_s   = sel ? rd1   : rd0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int nrise = 0;
    int first_rise = 0;
    int last_rise = 0;
    int last_fall = 0;
    int acc_cyc = 0;
    logic per_bad = 1'b0;
    logic sck_p = 1'b0;
    logic rdy_p = 1'b1;
    logic rdy_chk = 1'b0;
    logic [255:0] rec_o = '0;
    logic [255:0] rec_oe = '0;
    logic [255:0] tgt = '1;
    logic [31:0] last_rd = '0;
    exp_t exp_q[$];

    function automatic void chk(input string nm, input logic [255:0] act,
                                input logic [255:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s (dut%0d): got %0h, want %0h", nm, sel, act, req);
        end
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Pin recorder and target model: sample host bits at swclk rise,
    // present the next target bit after every clkin edge.
    always @(negedge clk) begin
        if (sck_s && !sck_p) begin
            if (nrise == 0) first_rise = cyc;
            else if (cyc - last_rise != 2 * (sel ? 1 : DIV0)) per_bad = 1'b1;
            last_rise = cyc;
            if (nrise < 256) begin
                rec_o[nrise]  = o_s;
                rec_oe[nrise] = oe_s;
            end
            nrise++;
        end
        if (!sck_s && sck_p) last_fall = cyc;
        if (!rdy_s && rdy_p) acc_cyc = cyc;
        sck_p = sck_s;
        rdy_p = rdy_s;
        tgt_i = (nrise < 256) ? tgt[nrise] : 1'b1;
    end

    // Response monitor: pops the scoreboard on every rsp_valid.
    always @(negedge clk) begin
        exp_t e;
        logic [255:0] mask;
        if (rdy_chk) begin
            rdy_chk = 1'b0;
            chk("ready_after_rsp", 256'(rdy_s), 256'(1));
        end
        if (vld_s) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp", 256'(1), 256'(0));
            end else begin
                e = exp_q.pop_front();
                mask = '0;
                for (int i = 0; i < e.nclk; i++) mask[i] = 1'b1;
                chk("ack", 256'(ack_s), 256'(e.ack));
                chk("rdata", 256'(rd_s), 256'(e.rd));
                chk("perr", 256'(perr_s), 256'(e.perr));
                chk("swclk_count", 256'(nrise), 256'(e.nclk));
                chk("oe_bits", rec_oe & mask, e.oe);
                chk("o_bits", rec_o & e.oe & mask, e.o & e.oe);
                chk("first_rise", 256'(first_rise - acc_cyc),
                    256'(sel ? 1 : DIV0));
                chk("period", 256'(per_bad), 256'(0));
                chk("latency", 256'(cyc - last_fall), 256'(1));
                chk("ready_during_rsp", 256'(rdy_s), 256'(0));
                chk("pins_parked", 256'({oe_s, o_s}), 256'(2'b01));
                rdy_chk = 1'b1;
            end
        end
    end

    task automatic issue(
        input logic [1:0]  c,
        input logic        a,
        input logic        r,
        input logic [1:0]  ad,
        input logic [7:0]  hdr,
        input logic [31:0] wd,
        input logic        wpar,
        input logic [2:0]  tack,
        input logic [31:0] td,
        input logic        tpar,
        input logic        eperr
    );
        exp_t e;
        logic [255:0] tg;
        logic [15:0] pat;
        int n;
        int k;
        pat = 16'hE79E;
        e.oe = '0;
        e.o = '0;
        e.rd = last_rd;
        e.perr = 1'b0;
        e.ack = '0;
        tg = '1;
        if (c == 2'd0) begin
            for (int i = 0; i < 8; i++) begin
                e.oe[i] = 1'b1;
                e.o[i] = hdr[i];
            end
            for (int i = 0; i < 3; i++) tg[9 + i] = tack[i];
            e.ack = tack;
            n = 13;
            if (tack == 3'b001 && r) begin
                for (int i = 0; i < 32; i++) tg[12 + i] = td[i];
                tg[44] = tpar;
                e.rd = td;
                e.perr = eperr;
                last_rd = td;
                n = 46;
            end else if (tack == 3'b001) begin
                for (int i = 0; i < 32; i++) begin
                    e.oe[13 + i] = 1'b1;
                    e.o[13 + i] = wd[i];
                end
                e.oe[45] = 1'b1;
                e.o[45] = wpar;
                n = 46;
            end
            for (int i = 0; i < IDLE_N; i++) e.oe[n + i] = 1'b1;
            e.nclk = n + IDLE_N;
        end else if (c == 2'd2) begin
            for (int i = 0; i < 136; i++) e.oe[i] = 1'b1;
            for (int i = 0; i < 56; i++) e.o[i] = 1'b1;
            for (int i = 0; i < 16; i++) e.o[56 + i] = pat[i];
            for (int i = 0; i < 56; i++) e.o[72 + i] = 1'b1;
            e.nclk = 136;
        end else begin
            for (int i = 0; i < 58; i++) e.oe[i] = 1'b1;
            for (int i = 0; i < 56; i++) e.o[i] = 1'b1;
            e.nclk = 58;
        end
        @(posedge clk);
        #1;
        nrise = 0;
        per_bad = 1'b0;
        rec_o = '0;
        rec_oe = '0;
        tgt = tg;
        cmd = c;
        ap = a;
        rnw = r;
        addr = ad;
        wdata = wd;
        exp_q.push_back(e);
        rv = 1'b1;
        k = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
        end while (rdy_s && k < 50);
        rv = 1'b0;
        chk("accept", 256'(rdy_s), 256'(0));
    endtask

    task automatic wait_rsp();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 20000) begin
            @(posedge clk);
            k++;
        end
        chk("rsp_timeout", 256'(exp_q.size()), 256'(0));
        exp_q.delete();
        repeat (2) @(posedge clk);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            chk("rst_swclk", 256'(sck_s), 256'(0));
            chk("rst_pins", 256'({oe_s, o_s}), 256'(2'b01));
            chk("rst_ready", 256'(rdy_s), 256'(1));
            chk("rst_rsp", 256'({vld_s, ack_s, rd_s, perr_s}), 256'(0));
        end
        rst = 1'b0;
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            last_rd = '0;
            #1;
            issue(2'd0, 0, 1, 2'd0, 8'hA5, 0, 0, 3'b001, 32'h2BA01477, 0, 0);
            wait_rsp();
            issue(2'd0, 0, 0, 2'd2, 8'hB1, 0, 0, 3'b001, 0, 0, 0);
            wait_rsp();
            issue(2'd0, 0, 1, 2'd0, 8'hA5, 0, 0, 3'b010, 0, 0, 0);
            wait_rsp();
            issue(2'd0, 1, 0, 2'd1, 8'h8B, 32'h12345678, 1, 3'b100, 0, 0, 0);
            wait_rsp();
            issue(2'd0, 1, 1, 2'd3, 8'h9F, 0, 0, 3'b001, 32'hDEADBEEF, 1, 1);
            wait_rsp();
            issue(2'd0, 1, 0, 2'd0, 8'hA3, 0, 0, 3'b111, 0, 0, 0);
            wait_rsp();
            issue(2'd0, 1, 0, 2'd1, 8'h8B, 32'h12345678, 1, 3'b001, 0, 0, 0);
            wait_rsp();
            issue(2'd2, 0, 0, 2'd0, 8'h00, 0, 0, 3'b000, 0, 0, 0);
            wait_rsp();
            issue(2'd1, 0, 0, 2'd0, 8'h00, 0, 0, 3'b000, 0, 0, 0);
            wait_rsp();
            issue(2'd3, 0, 0, 2'd0, 8'h00, 0, 0, 3'b000, 0, 0, 0);
            wait_rsp();
            issue(2'd0, 0, 1, 2'd1, 8'h8D, 0, 0, 3'b001, 32'hCAFEF00D, 0, 0);
            for (int k = 0; k < 5000 && nrise < 20; k++) @(posedge clk);
            #1;
            chk("reach_rdata", 256'(nrise >= 20), 256'(1));
            rst = 1'b1;
            #1;
            chk("midrst_swclk", 256'(sck_s), 256'(0));
            chk("midrst_oe", 256'(oe_s), 256'(0));
            chk("midrst_ready", 256'(rdy_s), 256'(1));
            chk("midrst_rsp", 256'({vld_s, rd_s}), 256'(0));
            if (exp_q.size() != 0) void'(exp_q.pop_back());
            last_rd = '0;
            repeat (3) @(posedge clk);
            #1;
            rst = 1'b0;
            repeat (5) @(posedge clk);
            issue(2'd0, 0, 1, 2'd1, 8'h8D, 0, 0, 3'b001, 32'h00000001, 1, 0);
            wait_rsp();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/swd_host.md
# swd_host

Parametrised Serial Wire Debug host engine for simulation and bring-up benches. It replaces a fixed, hard-coded SWD command player with a request/response interface. Each accepted request is one of three commands: a complete SWD transfer (header, ACK, data, parity), a line reset, or a JTAG-to-SWD switch sequence. Read data, ACK and parity status are returned to the requester. The block sits between a bench or firmware-model sequencer and the SWCLK/SWDIO pads of the device under test.

## Interface
- DIV_HALF, 24: clkin cycles per SWCLK half-period; legal range 1..255.
- IDLE_CYCLES, 8: SWCLK cycles with SWDIO driven low after every transfer; legal range 0..63.
- clkin  input  1  sole clock; all state changes on its rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req_valid  input  1  request present.
- req_ready  output  1  engine idle; request accepted on req_valid && req_ready.
- req_cmd  input  2  0 = transfer, 1 = line reset, 2 = JTAG-to-SWD; 3 is treated as 1.
- req_ap  input  1  APnDP bit of the header.
- req_rnw  input  1  RnW bit of the header.
- req_addr  input  2  A[3:2] of the header.
- req_wdata  input  32  write data; captured when the request is accepted.
- rsp_valid  output  1  one-clkin-cycle pulse when the command completes.
- rsp_ack  output  3  ACK sampled from the target, LSB received first; 3'b000 for non-transfer commands.
- rsp_rdata  output  32  read data; holds its last value when the command is not a read with ACK OK.
- rsp_perr  output  1  read-data parity mismatch.
- swclk  output  1  SWD clock.
- swdio_o  output  1  SWDIO drive value.
- swdio_oe  output  1  SWDIO output enable; pad tri-states when low.
- swdio_i  input  1  SWDIO pad value.

## Operation
- Reset values: swclk 0, swdio_o 1, swdio_oe 0, req_ready 1, rsp_valid 0, rsp_ack 0, rsp_rdata 0, rsp_perr 0, state IDLE.
- Reset is asynchronous. Asserting it mid-command forces the reset values immediately, and no rsp_valid is issued.
- FSM states: IDLE, SEQ, HDR, TRN1, ACK, RDATA, TRN2, WDATA, TAIL, DONE.
- On accept, the engine leaves IDLE and req_ready drops in the next cycle. req_cmd 1 and 2 go to SEQ; req_cmd 0 goes to HDR.
- SEQ, line reset: 56 ones, then 2 zeros.
- SEQ, JTAG-to-SWD: 56 ones, then 16'hE79E sent LSB-first, then 56 ones, then 8 zeros (136 bits in total).
- HDR: 8 bits sent LSB-first: start 1, APnDP, RnW, A2, A3, parity, stop 0, park 1. Parity = APnDP ^ RnW ^ A2 ^ A3. Example: DP read at address 0 gives header 8'hA5.
- TRN1: 1 cycle with swdio_oe = 0.
- ACK: 3 bits sampled. OK = 3'b001, WAIT = 3'b010, FAULT = 3'b100; any other value is a protocol error.
- If ACK is OK and the request is a read: RDATA receives 32 bits plus 1 parity bit, LSB-first. Then TRN2, then TAIL.
- If ACK is OK and the request is a write: TRN2, then WDATA drives 32 bits plus even parity, LSB-first. Then TAIL.
- If ACK is not OK: TRN2, then TAIL. No data phase.
- rsp_perr = (XOR of the 32 data bits) != parity bit. It is cleared for every command that is not a read.
- TAIL: drives IDLE_CYCLES zeros with swdio_oe = 1.
- DONE: rsp_valid = 1 for one cycle, then back to IDLE with req_ready = 1.
- After TAIL (and after SEQ), swdio_o returns to 1 and swdio_oe returns to 0.

## Timing
- SWCLK period is 2*DIV_HALF clkin cycles. swclk idles low and starts its first high half DIV_HALF cycles after a request is accepted.
- Host drive: swdio_o and swdio_oe change only in the cycle where swclk goes from 1 to 0, except the first bit, which is set up at acceptance.
- Host sample: swdio_i is sampled in the cycle where swclk goes from 0 to 1.
- SWCLK cycles per transfer: OK read or OK write = 46 + IDLE_CYCLES; WAIT/FAULT/error = 13 + IDLE_CYCLES.
- Command latency: rsp_valid rises 1 clkin cycle after the last falling edge of swclk.
- A new request presented in the same cycle that rsp_valid is high is not accepted. It is accepted in the next cycle.
- Edge case DIV_HALF = 1: swclk toggles every clkin cycle, and sampling and driving still fall on the correct edges.

## Structure
- swd_pkg holds: the cmd enum; the ack constants (ACK_OK, ACK_WAIT, ACK_FAULT); the state enum; LINE_RESET_LEN = 56; JTAG2SWD = 16'hE79E.
- Sub-module swd_clkgen: a DIV_HALF counter that produces swclk and one-cycle rise/fall strobes, plus an enable input that holds swclk low while the engine is idle.
- A single bit counter (7 bits) and a single shift register (33 bits) are shared by all phases.

## Test plan
- DP read at address 0, target returns ACK 3'b001 and data 32'h2BA01477 with parity 0 -> header 8'hA5 observed on the pins; rsp_ack = 001, rsp_rdata = 32'h2BA01477, rsp_perr = 0; 54 SWCLK cycles.
- Write DP SELECT with data 0 -> header 8'hB1; 33 data+parity bits all 0; swdio_oe low only during the two turnaround cycles; rsp_ack = 001.
- Target answers WAIT -> rsp_ack = 010, no data phase, 21 SWCLK cycles. Repeat with FAULT -> rsp_ack = 100.
- Read with a corrupted parity bit -> rsp_perr = 1; rsp_rdata still updated.
- JTAG-to-SWD command -> exactly 136 bits on the pins (ones, then 16'hE79E LSB-first, then ones, then zeros); rsp_ack = 0.
- rst asserted during RDATA -> same cycle: swclk = 0, swdio_oe = 0, req_ready = 1, and no rsp_valid. A following read completes normally. Also run with DIV_HALF = 1.
